// File: rtl/seven_seg_scan_driver_if.sv
// Display bus between the clock datapath and the 7-segment scan driver.
// The datapath side drives the number; the driver side returns segment/anode/busy.
interface seven_seg_scan_driver_if;
  logic [15:0] i_display_num;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_busy;

  modport master (
    output i_display_num,
    input  o_seg,
    input  o_dp,
    input  o_an,
    input  o_busy
  );

  modport slave (
    input  i_display_num,
    output o_seg,
    output o_dp,
    output o_an,
    output o_busy
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Two 8-bit binary fields -> BCD via sequential double-dabble, then a 4-digit
// time-multiplexed 7-segment scan with registered seg/an/dp outputs.
//
// state  | meaning
// IDLE   | display shows bcd_reg; waits for a new or first display_num
// CONV   | 8 shift-add-3 steps on both fields in parallel
// COMMIT | latch BCD digits and out-of-range flags, mark display valid
module seven_seg_scan_driver #(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b0
) (
  input logic                     clk,
  input logic                     reset,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_start;
  logic           w_step;
  logic           w_commit;

  logic           r_valid;
  logic [15:0]    r_cap;
  logic [7:0]     r_bin_hi;
  logic [7:0]     r_bin_lo;
  logic [11:0]    r_acc_hi;
  logic [11:0]    r_acc_lo;
  logic [2:0]     r_cnt;
  // {range_hi, range_lo, hi_tens, hi_ones, lo_tens, lo_ones}
  logic [17:0]    r_bcd;

  logic [PW-1:0]  r_presc;
  logic [1:0]     r_idx;

  logic [6:0]     r_seg_on;
  logic [3:0]     r_an_on;
  logic           r_dp_on;

  logic [19:0]    w_dd_hi;
  logic [19:0]    w_dd_lo;
  logic [3:0]     w_digit;
  logic           w_dash;
  logic           w_blank;
  logic [6:0]     w_code;
  logic [3:0]     w_an_oh;
  logic           w_dp_oh;

  function automatic logic [19:0] f_dd_step(input logic [11:0] acc, input logic [7:0] bin);
    logic [11:0] a;
    a = acc;
    for (int i = 0; i < 3; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[10:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_valid || (bus.i_display_num != r_cap)) begin
          w_start     = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_step = 1'b1;
        if (r_cnt == 3'd7) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_dd_hi = f_dd_step(r_acc_hi, r_bin_hi);
  assign w_dd_lo = f_dd_step(r_acc_lo, r_bin_lo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_cap    <= '0;
      r_bin_hi <= '0;
      r_bin_lo <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
    end else begin
      if (w_start) begin
        r_cap    <= bus.i_display_num;
        r_bin_hi <= bus.i_display_num[15:8];
        r_bin_lo <= bus.i_display_num[7:0];
        r_acc_hi <= '0;
        r_acc_lo <= '0;
        r_cnt    <= '0;
      end
      if (w_step) begin
        r_acc_hi <= w_dd_hi[19:8];
        r_bin_hi <= w_dd_hi[7:0];
        r_acc_lo <= w_dd_lo[19:8];
        r_bin_lo <= w_dd_lo[7:0];
        r_cnt    <= r_cnt + 3'd1;
      end
      if (w_commit) begin
        r_bcd   <= {(r_acc_hi[11:8] != 4'd0), (r_acc_lo[11:8] != 4'd0),
                    r_acc_hi[7:0], r_acc_lo[7:0]};
        r_valid <= 1'b1;
      end
    end
  end

  // Scan timing free-runs regardless of conversion activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_dash  = 1'b0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin w_digit = r_bcd[3:0];   w_dash = r_bcd[16]; end
      2'd1: begin w_digit = r_bcd[7:4];   w_dash = r_bcd[16]; end
      2'd2: begin w_digit = r_bcd[11:8];  w_dash = r_bcd[17]; end
      default: begin
        w_digit = r_bcd[15:12];
        w_dash  = r_bcd[17];
        w_blank = BLANK_LZ && (r_bcd[15:12] == 4'd0) && !r_bcd[17];
      end
    endcase
    w_code  = w_blank ? 7'h00 : (w_dash ? 7'h40 : f_seg(w_digit));
    w_an_oh = 4'b0001 << r_idx;
    w_dp_oh = (r_idx == 2'd2);
    if (!r_valid) begin
      w_code  = 7'h00;
      w_an_oh = 4'b0000;
      w_dp_oh = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_on <= '0;
      r_an_on  <= '0;
      r_dp_on  <= 1'b0;
    end else begin
      r_seg_on <= w_code;
      r_an_on  <= w_an_oh;
      r_dp_on  <= w_dp_oh;
    end
  end

  assign bus.o_seg  = SEG_ACTIVE_LOW ? ~r_seg_on : r_seg_on;
  assign bus.o_an   = SEG_ACTIVE_LOW ? ~r_an_on  : r_an_on;
  assign bus.o_dp   = SEG_ACTIVE_LOW ? ~r_dp_on  : r_dp_on;
  assign bus.o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: reset, conversion latency, scan order,
// out-of-range dash, last-value-wins, leading-zero blanking and reset mid-conversion.
module tb_seven_seg_scan_driver;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset;
  logic sel = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  seven_seg_scan_driver_if if_a();
  seven_seg_scan_driver_if if_b();

  seven_seg_scan_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  seven_seg_scan_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] w_seg;
  logic       w_dp;
  logic [3:0] w_an;
  logic       w_busy;
  assign w_seg  = sel ? if_b.o_seg  : if_a.o_seg;
  assign w_dp   = sel ? if_b.o_dp   : if_a.o_dp;
  assign w_an   = sel ? if_b.o_an   : if_a.o_an;
  assign w_busy = sel ? if_b.o_busy : if_a.o_busy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int k = 0;
    while (w_an !== target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 16'(w_an), 16'(target));
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int k = 0;
    while (w_busy !== val && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 16'(w_busy), 16'(val));
  endtask

  // Aligns to the first cycle of slot 0, then checks every cycle of one full scan.
  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] es [4];
    logic [3:0] an_tab [4];
    es     = '{e0, e1, e2, e3};
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    wait_an(4'h7, {tag, "_sync3"});
    wait_an(4'hE, {tag, "_sync0"});
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SD; c++) begin
        chk($sformatf("%s_an_d%0d_c%0d", tag, s, c), 16'(w_an), 16'(an_tab[s]));
        chk($sformatf("%s_seg_d%0d_c%0d", tag, s, c), 16'(w_seg), 16'(es[s]));
        chk($sformatf("%s_dp_d%0d_c%0d", tag, s, c), 16'(w_dp), (s == 2) ? 16'd0 : 16'd1);
        @(negedge clk);
      end
    end
    chk({tag, "_wrap"}, 16'(w_an), 16'hE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    if_a.i_display_num = 16'h0000;
    if_b.i_display_num = 16'h0509;

    // T1: reset state, then first conversion of 0
    repeat (3) @(negedge clk);
    chk("t1_rst_seg", 16'(w_seg), 16'h7F);
    chk("t1_rst_dp", 16'(w_dp), 16'h1);
    chk("t1_rst_an", 16'(w_an), 16'hF);
    chk("t1_rst_busy", 16'(w_busy), 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_%0d", i), 16'(w_busy), 16'h1);
    end
    @(negedge clk);
    chk("t1_busy_done", 16'(w_busy), 16'h0);
    check_frame("t1", 7'h40, 7'h40, 7'h40, 7'h40);

    // T2: 12|34
    if_a.i_display_num = 16'h0C22;
    @(negedge clk);
    chk("t2_busy", 16'(w_busy), 16'h1);
    wait_busy(1'b0, "t2_done");
    check_frame("t2", 7'h19, 7'h30, 7'h24, 7'h79);

    // T3: 59|150, lower field out of range
    if_a.i_display_num = 16'h3B96;
    @(negedge clk);
    wait_busy(1'b0, "t3_done");
    check_frame("t3", 7'h3F, 7'h3F, 7'h10, 7'h12);

    // T4: changes while busy; intermediate 0105 must never be committed
    if_a.i_display_num = 16'h0000;
    @(negedge clk);
    chk("t4_busy", 16'(w_busy), 16'h1);
    if_a.i_display_num = 16'h0105;
    repeat (2) @(negedge clk);
    if_a.i_display_num = 16'h0207;
    wait_busy(1'b0, "t4_first_done");
    @(negedge clk);
    chk("t4_restart", 16'(w_busy), 16'h1);
    chk("t4_zero_a", 16'(w_seg), 16'h40);
    repeat (3) @(negedge clk);
    chk("t4_zero_b", 16'(w_seg), 16'h40);
    wait_busy(1'b0, "t4_second_done");
    check_frame("t4", 7'h78, 7'h40, 7'h24, 7'h40);

    // T5: leading-zero blanking instance showing 05|09
    sel = 1'b1;
    check_frame("t5", 7'h10, 7'h40, 7'h12, 7'h7F);
    sel = 1'b0;

    // T6: reset at CONV cycle 4
    if_a.i_display_num = 16'h2A63;
    @(negedge clk);
    chk("t6_busy", 16'(w_busy), 16'h1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_seg", 16'(w_seg), 16'h7F);
    chk("t6_rst_an", 16'(w_an), 16'hF);
    chk("t6_rst_dp", 16'(w_dp), 16'h1);
    chk("t6_rst_busy", 16'(w_busy), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("t6_busy_%0d", i), 16'(w_busy), 16'h1);
      chk($sformatf("t6_an_off_%0d", i), 16'(w_an), 16'hF);
    end
    @(negedge clk);
    chk("t6_busy_done", 16'(w_busy), 16'h0);
    chk("t6_an_commit", 16'(w_an), 16'hF);
    @(negedge clk);
    chk("t6_an_on", 16'(w_an != 4'hF), 16'h1);
    check_frame("t6", 7'h10, 7'h10, 7'h24, 7'h19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
